// File: rtl/prbs_pkg.sv
// Shared PRBS-31 constants, checker state type and word-level helper functions.
package prbs_pkg;

  localparam int PRBS31_LEN = 31;
  localparam int PRBS31_TAP = 28;
  // Widest word the helpers support; callers zero-extend / truncate to their width.
  localparam int MAX_W      = 256;
  localparam int POP_W      = 9;   // $clog2(MAX_W+1)

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Next `width` PRBS-31 bits following seed (seed[30] is the most recent bit).
  // Bit 0 of the result is earliest in time. Bits at and above `width` are zero.
  function automatic logic [MAX_W-1:0] prbs31_next_word(input logic [PRBS31_LEN-1:0] seed,
                                                        input int width);
    logic [MAX_W+PRBS31_LEN-1:0] hist;
    logic [MAX_W-1:0]            word;
    hist                   = '0;
    hist[PRBS31_LEN-1:0]   = seed;
    word                   = '0;
    for (int i = 0; i < MAX_W; i++) begin
      // s[n] = s[n-31] ^ s[n-28]
      hist[PRBS31_LEN+i] = hist[i] ^ hist[i+PRBS31_LEN-PRBS31_TAP];
      if (i < width) word[i] = hist[PRBS31_LEN+i];
    end
    return word;
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [MAX_W-1:0] v);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_W; i++) cnt = cnt + POP_W'(v[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/prbs_word_checker_predict.sv
// prbs31_predict: combinational seed -> predicted word and the seed that follows it.
module prbs31_predict
  import prbs_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [PRBS31_LEN-1:0] seed,
  output logic [DATA_W-1:0]     pred,
  output logic [PRBS31_LEN-1:0] next_seed
);

  assign pred      = DATA_W'(prbs31_next_word(seed, DATA_W));
  // The last 31 predicted bits are the history for the following word.
  assign next_seed = pred[DATA_W-1 -: PRBS31_LEN];

endmodule

// File: rtl/prbs_word_checker.sv
// Word-parallel PRBS-31 checker: self-synchronising hunt, locked compare,
// registered per-word pulses for the downstream error/word counters.
module prbs_word_checker
  import prbs_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int LOCK_WORDS  = 16,
  parameter int UNLOCK_ERRS = 8,
  parameter int CNT_W       = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       resync,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       data_valid,
  output logic                       locked,
  output logic                       word_chk,
  output logic                       err_word,
  output logic [$clog2(DATA_W+1)-1:0] err_bits,
  output logic                       lock_lost
);

  localparam int EW = $clog2(DATA_W+1);

  state_t                 state, state_n;
  logic                   have_prev, have_prev_n;
  logic [CNT_W-1:0]       good_run, good_run_n, good_inc;
  logic [CNT_W-1:0]       bad_run, bad_run_n, bad_inc;
  logic [PRBS31_LEN-1:0]  seed, seed_n, pred_seed, rx_tail;
  logic [DATA_W-1:0]      pred, diff;
  logic                   word_chk_n, err_word_n, lock_lost_n;
  logic [EW-1:0]          err_bits_n;

  prbs31_predict #(.DATA_W(DATA_W)) u_predict (
    .seed      (seed),
    .pred      (pred),
    .next_seed (pred_seed)
  );

  assign rx_tail  = data_in[DATA_W-1 -: PRBS31_LEN];
  assign diff     = data_in ^ pred;
  // Run counters saturate rather than wrap.
  assign good_inc = (good_run == '1) ? good_run : good_run + CNT_W'(1);
  assign bad_inc  = (bad_run  == '1) ? bad_run  : bad_run  + CNT_W'(1);
  assign locked   = (state == LOCKED);

  // Next-state, run counters, seed update and output pulses.
  always_comb begin
    state_n     = state;
    have_prev_n = have_prev;
    good_run_n  = good_run;
    bad_run_n   = bad_run;
    seed_n      = seed;
    word_chk_n  = 1'b0;
    err_word_n  = 1'b0;
    err_bits_n  = '0;
    lock_lost_n = 1'b0;

    if (resync) begin
      // Same-cycle data is discarded.
      state_n     = HUNT;
      have_prev_n = 1'b0;
      good_run_n  = '0;
      bad_run_n   = '0;
      lock_lost_n = (state == LOCKED);
    end else if (data_valid) begin
      unique case (state)
        HUNT: begin
          // Always resync the seed to what was received.
          seed_n      = rx_tail;
          have_prev_n = 1'b1;
          if (have_prev) begin
            if (diff == '0) begin
              if (good_inc >= CNT_W'(LOCK_WORDS)) begin
                state_n    = LOCKED;
                good_run_n = '0;
                bad_run_n  = '0;
              end else begin
                good_run_n = good_inc;
              end
            end else begin
              good_run_n = '0;
            end
          end
        end
        LOCKED: begin
          // Free-run on the prediction so line errors do not poison the seed.
          seed_n     = pred_seed;
          word_chk_n = 1'b1;
          if (diff != '0) begin
            err_word_n = 1'b1;
            err_bits_n = EW'(popcount(MAX_W'(diff)));
            if (bad_inc >= CNT_W'(UNLOCK_ERRS)) begin
              state_n     = HUNT;
              have_prev_n = 1'b0;
              good_run_n  = '0;
              bad_run_n   = '0;
              lock_lost_n = 1'b1;
            end else begin
              bad_run_n = bad_inc;
            end
          end else begin
            bad_run_n = '0;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  // State and output registers; reset clears everything including pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HUNT;
      have_prev <= 1'b0;
      good_run  <= '0;
      bad_run   <= '0;
      seed      <= '0;
      word_chk  <= 1'b0;
      err_word  <= 1'b0;
      err_bits  <= '0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_n;
      have_prev <= have_prev_n;
      good_run  <= good_run_n;
      bad_run   <= bad_run_n;
      seed      <= seed_n;
      word_chk  <= word_chk_n;
      err_word  <= err_word_n;
      err_bits  <= err_bits_n;
      lock_lost <= lock_lost_n;
    end
  end

endmodule
